cim_core_req_router: RTL and testbench



---
 rtl/cim_core_router_pkg.sv | 17 +
 rtl/cim_core_err_resp.sv | 32 +++
 rtl/cim_core_req_router.sv | 155 +++++++++++++++
 tb/tb_cim_core_req_router.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_core_router_pkg.sv
// Shared types and constants for the CIM core request router.
package cim_core_router_pkg;

    localparam int ERR_CNT_W = 16;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } rule_t;

    // Counter width that can hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cim_core_err_resp.sv
// Local error-response generator: answers accepted decode-error requests
// one per cycle, one cycle after acceptance at the earliest.
module cim_core_err_resp
    import cim_core_router_pkg::*;
#(
    parameter int MaxTrans = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    output logic emit_o,
    output logic err_valid_o
);

    localparam int CntW = cnt_width(MaxTrans);

    logic [CntW-1:0] pend;

    // A fresh error can be answered at the very next edge, so it counts as emittable now.
    assign emit_o = push_i || (pend != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend        <= '0;
            err_valid_o <= 1'b0;
        end else begin
            pend        <= pend + CntW'(push_i) - CntW'(emit_o);
            err_valid_o <= emit_o;
        end
    end

endmodule

// File: rtl/cim_core_req_router.sv
// Routes the core's req/gnt port to NoTargets targets with in-order responses.
// Optional saturating error counter enabled by CIM_CORE_ROUTER_ERR_CNT_EN.
module cim_core_req_router
    import cim_core_router_pkg::*;
#(
    parameter int NoRules        = 4,
    parameter int NoTargets      = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MaxTrans       = 4,
    parameter int IdxWidth       = (NoTargets > 1) ? $clog2(NoTargets) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  rule_t [NoRules-1:0]                 addr_map_i,
    input  logic                                slv_req_i,
    output logic                                slv_gnt_o,
    input  logic [AXI_ADDR_WIDTH-1:0]           slv_addr_i,
    input  logic                                slv_we_i,
    input  logic [DATA_WIDTH-1:0]               slv_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]             slv_be_i,
    output logic                                slv_rvalid_o,
    output logic [DATA_WIDTH-1:0]               slv_rdata_o,
    output logic                                slv_err_o,
    output logic [NoTargets-1:0]                mst_req_o,
    input  logic [NoTargets-1:0]                mst_gnt_i,
    output logic [AXI_ADDR_WIDTH-1:0]           mst_addr_o,
    output logic                                mst_we_o,
    output logic [DATA_WIDTH-1:0]               mst_wdata_o,
    output logic [DATA_WIDTH/8-1:0]             mst_be_o,
    input  logic [NoTargets-1:0]                mst_rvalid_i,
    input  logic [NoTargets-1:0][DATA_WIDTH-1:0] mst_rdata_i,
    output logic [ERR_CNT_W-1:0]                err_cnt_o
);

    localparam int CntW = cnt_width(MaxTrans);

    logic                dec_valid;
    logic [IdxWidth-1:0] tgt;
    logic                stall;
    logic                same_dest;
    logic                accept;
    logic                err_push;
    logic                tgt_resp;
    logic                err_emit;
    logic                err_valid;
    logic                rsp_valid;
    logic [CntW-1:0]     cnt;
    logic [IdxWidth-1:0] cur_tgt;
    logic                cur_err;

    assign mst_addr_o  = slv_addr_i;
    assign mst_we_o    = slv_we_i;
    assign mst_wdata_o = slv_wdata_i;
    assign mst_be_o    = slv_be_i;

    // Later rules override earlier ones; an out-of-range index decodes as an error.
    always_comb begin
        dec_valid = 1'b0;
        tgt       = '0;
        for (int i = 0; i < NoRules; i++) begin
            if (slv_addr_i >= AXI_ADDR_WIDTH'(addr_map_i[i].start_addr) &&
                slv_addr_i <  AXI_ADDR_WIDTH'(addr_map_i[i].end_addr)) begin
                dec_valid = (addr_map_i[i].idx < 32'(NoTargets));
                tgt       = addr_map_i[i].idx[IdxWidth-1:0];
            end
        end
    end

    assign same_dest = dec_valid ? (!cur_err && tgt == cur_tgt) : cur_err;
    assign stall     = (cnt == CntW'(MaxTrans)) || (cnt != '0 && !same_dest);

    always_comb begin
        mst_req_o = '0;
        slv_gnt_o = 1'b0;
        if (!rst_i && !stall) begin
            if (dec_valid) begin
                mst_req_o[tgt] = slv_req_i;
                slv_gnt_o      = mst_gnt_i[tgt];
            end else begin
                slv_gnt_o = slv_req_i;
            end
        end
    end

    assign accept   = slv_req_i && slv_gnt_o;
    assign err_push = accept && !dec_valid;
    assign tgt_resp = !rst_i && mst_rvalid_i[cur_tgt] && cnt != '0 && !cur_err;

    cim_core_err_resp #(
        .MaxTrans (MaxTrans)
    ) u_err_resp (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (err_push),
        .emit_o      (err_emit),
        .err_valid_o (err_valid)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt         <= '0;
            cur_tgt     <= '0;
            cur_err     <= 1'b0;
            rsp_valid   <= 1'b0;
            slv_rdata_o <= '0;
        end else begin
            cnt <= cnt + CntW'(accept) - CntW'(tgt_resp || err_emit);
            if (accept) begin
                cur_err <= !dec_valid;
                if (dec_valid) begin
                    cur_tgt <= tgt;
                end
            end
            rsp_valid   <= tgt_resp;
            slv_rdata_o <= tgt_resp ? mst_rdata_i[cur_tgt] : '0;
        end
    end

    assign slv_rvalid_o = rsp_valid || err_valid;
    assign slv_err_o    = err_valid;

`ifdef CIM_CORE_ROUTER_ERR_CNT_EN
    localparam int SumW = ERR_CNT_W + 1;

    logic [NoTargets-1:0] spur;
    logic [SumW-1:0]      err_sum;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Every rvalid bit not consumed as the in-order response is spurious.
    always_comb begin
        spur = mst_rvalid_i;
        if (tgt_resp) begin
            spur[cur_tgt] = 1'b0;
        end
        err_sum = {1'b0, err_cnt_q} + SumW'(err_push);
        for (int i = 0; i < NoTargets; i++) begin
            err_sum = err_sum + SumW'(spur[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cim_core_req_router.sv
// Self-checking bench for cim_core_req_router: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_cim_core_req_router;
    import cim_core_router_pkg::*;

    localparam int NT = 4;
    localparam int NR = 4;
    localparam int MT = 4;

`ifdef CIM_CORE_ROUTER_ERR_CNT_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic                clk_i = 1'b0;
    logic                rst_i;
    rule_t [NR-1:0]      addr_map_i;
    logic                slv_req_i;
    logic                slv_gnt_o;
    logic [31:0]         slv_addr_i;
    logic                slv_we_i;
    logic [31:0]         slv_wdata_i;
    logic [3:0]          slv_be_i;
    logic                slv_rvalid_o;
    logic [31:0]         slv_rdata_o;
    logic                slv_err_o;
    logic [NT-1:0]       mst_req_o;
    logic [NT-1:0]       mst_gnt_i;
    logic [31:0]         mst_addr_o;
    logic                mst_we_o;
    logic [31:0]         mst_wdata_o;
    logic [3:0]          mst_be_o;
    logic [NT-1:0]       mst_rvalid_i;
    logic [NT-1:0][31:0] mst_rdata_i;
    logic [15:0]         err_cnt_o;

    int checks   = 0;
    int failures = 0;

    // Reference model state: destinations of outstanding requests, oldest first (-1 = error).
    int          q[$];
    int          errCntM;
    int          expCnt;
    logic        mGnt;
    logic [3:0]  mReq;
    logic        expRv, expErr, nxtRv, nxtErr;
    logic [31:0] expRd, nxtRd;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [3:0]  gnt;
        logic [3:0]  rv;
        logic [31:0] rd;
        logic        eGnt;
        logic [3:0]  eReq;
        logic        eRv;
        logic        eErr;
        logic [31:0] eRd;
        logic [15:0] eCnt;
    } vec_t;

    vec_t vecs[18];

    cim_core_req_router #(
        .NoRules        (NR),
        .NoTargets      (NT),
        .AXI_ADDR_WIDTH (32),
        .DATA_WIDTH     (32),
        .MaxTrans       (MT)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .addr_map_i   (addr_map_i),
        .slv_req_i    (slv_req_i),
        .slv_gnt_o    (slv_gnt_o),
        .slv_addr_i   (slv_addr_i),
        .slv_we_i     (slv_we_i),
        .slv_wdata_i  (slv_wdata_i),
        .slv_be_i     (slv_be_i),
        .slv_rvalid_o (slv_rvalid_o),
        .slv_rdata_o  (slv_rdata_o),
        .slv_err_o    (slv_err_o),
        .mst_req_o    (mst_req_o),
        .mst_gnt_i    (mst_gnt_i),
        .mst_addr_o   (mst_addr_o),
        .mst_we_o     (mst_we_o),
        .mst_wdata_o  (mst_wdata_o),
        .mst_be_o     (mst_be_o),
        .mst_rvalid_i (mst_rvalid_i),
        .mst_rdata_i  (mst_rdata_i),
        .err_cnt_o    (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] ec(input int n);
        return ErrEn ? 16'(n) : 16'd0;
    endfunction

    function automatic int decodeDest(input logic [31:0] a);
        int d;
        d = -1;
        for (int i = 0; i < NR; i++) begin
            if (a >= addr_map_i[i].start_addr && a < addr_map_i[i].end_addr) begin
                d = (addr_map_i[i].idx < NT) ? int'(addr_map_i[i].idx) : -1;
            end
        end
        return d;
    endfunction

    // One cycle of the reference model, evaluated on the inputs currently driven.
    task automatic modelStep();
        int dest;
        int pre;
        int fwd;
        int inc;
        bit stall;
        expRv  = nxtRv;
        expErr = nxtErr;
        expRd  = nxtRd;
        expCnt = errCntM;
        mGnt   = 1'b0;
        mReq   = '0;
        if (rst_i) begin
            q.delete();
            errCntM = 0;
            nxtRv   = 1'b0;
            nxtErr  = 1'b0;
            nxtRd   = '0;
            return;
        end
        dest  = decodeDest(slv_addr_i);
        pre   = q.size();
        stall = (pre == MT) || (pre != 0 && q[0] != dest);
        if (!stall) begin
            if (dest >= 0) begin
                mReq[dest] = slv_req_i;
                mGnt       = mst_gnt_i[dest];
            end else begin
                mGnt = slv_req_i;
            end
        end
        if (slv_req_i && mGnt) q.push_back(dest);
        nxtRv  = 1'b0;
        nxtErr = 1'b0;
        nxtRd  = '0;
        fwd    = -1;
        if (q.size() != 0) begin
            if (q[0] < 0) begin
                nxtRv  = 1'b1;
                nxtErr = 1'b1;
                void'(q.pop_front());
            end else if (pre != 0 && mst_rvalid_i[q[0]]) begin
                fwd   = q[0];
                nxtRv = 1'b1;
                nxtRd = mst_rdata_i[fwd];
                void'(q.pop_front());
            end
        end
        inc = (slv_req_i && mGnt && dest < 0) ? 1 : 0;
        for (int i = 0; i < NT; i++) begin
            if (mst_rvalid_i[i] && i != fwd) inc++;
        end
        if (ErrEn) errCntM = (errCntM + inc > 65535) ? 65535 : errCntM + inc;
    endtask

    task automatic applyStimulus(input logic rst, input logic req, input logic [31:0] addr,
                                 input logic [3:0] gnt, input logic [3:0] rv,
                                 input logic [NT-1:0][31:0] rd);
        @(negedge clk_i);
        rst_i        = rst;
        slv_req_i    = req;
        slv_addr_i   = addr;
        slv_we_i     = addr[2];
        slv_wdata_i  = ~addr;
        slv_be_i     = addr[7:4];
        mst_gnt_i    = gnt;
        mst_rvalid_i = rv;
        mst_rdata_i  = rd;
        #1;
        modelStep();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkModel();
        checkOutput("rnd_gnt", 32'(slv_gnt_o), 32'(mGnt));
        checkOutput("rnd_mst_req", 32'(mst_req_o), 32'(mReq));
        checkOutput("rnd_rvalid", 32'(slv_rvalid_o), 32'(expRv));
        checkOutput("rnd_err", 32'(slv_err_o), 32'(expErr));
        checkOutput("rnd_rdata", slv_rdata_o, expRd);
        checkOutput("rnd_err_cnt", 32'(err_cnt_o), 32'(expCnt));
        checkOutput("rnd_mst_addr", mst_addr_o, slv_addr_i);
    endtask

    initial begin
        logic [31:0]         addrs[7];
        logic [NT-1:0][31:0] rdr;
        logic                rreq;
        logic                rrst;

        rst_i        = 1'b1;
        slv_req_i    = 1'b0;
        slv_addr_i   = '0;
        slv_we_i     = 1'b0;
        slv_wdata_i  = '0;
        slv_be_i     = '0;
        mst_gnt_i    = '0;
        mst_rvalid_i = '0;
        mst_rdata_i  = '0;
        q.delete();
        errCntM = 0;
        nxtRv   = 1'b0;
        nxtErr  = 1'b0;
        nxtRd   = '0;

        addr_map_i[0] = '{32'd1, 32'h1000, 32'h2000};
        addr_map_i[1] = '{32'd2, 32'h2000, 32'h3000};
        addr_map_i[2] = '{32'd3, 32'h3000, 32'h4000};
        addr_map_i[3] = '{32'd0, 32'h1800, 32'h1900};

        //             req   addr      gnt      rv       rd            eGnt  eReq     eRv   eErr  eRd           eCnt
        vecs[0]  = '{1'b0, 32'h0,    4'b0000, 4'b0000, 32'h0,        1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        ec(0)};
        vecs[1]  = '{1'b1, 32'h1004, 4'b0010, 4'b0000, 32'h0,        1'b1, 4'b0010, 1'b0, 1'b0, 32'h0,        ec(0)};
        vecs[2]  = '{1'b0, 32'h0,    4'b0000, 4'b0010, 32'hDEADBEEF, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        ec(0)};
        vecs[3]  = '{1'b0, 32'h0,    4'b0000, 4'b0000, 32'h0,        1'b0, 4'b0000, 1'b1, 1'b0, 32'hDEADBEEF, ec(0)};
        vecs[4]  = '{1'b1, 32'h9000, 4'b0000, 4'b0000, 32'h0,        1'b1, 4'b0000, 1'b0, 1'b0, 32'h0,        ec(0)};
        vecs[5]  = '{1'b0, 32'h0,    4'b0000, 4'b0000, 32'h0,        1'b0, 4'b0000, 1'b1, 1'b1, 32'h0,        ec(1)};
        vecs[6]  = '{1'b0, 32'h0,    4'b0000, 4'b1000, 32'h0,        1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        ec(1)};
        vecs[7]  = '{1'b0, 32'h0,    4'b0000, 4'b0000, 32'h0,        1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        ec(2)};
        vecs[8]  = '{1'b1, 32'h1FFF, 4'b0010, 4'b0000, 32'h0,        1'b1, 4'b0010, 1'b0, 1'b0, 32'h0,        ec(2)};
        vecs[9]  = '{1'b1, 32'h2000, 4'b0100, 4'b0000, 32'h0,        1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        ec(2)};
        vecs[10] = '{1'b1, 32'h2000, 4'b0100, 4'b0010, 32'h12345678, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        ec(2)};
        vecs[11] = '{1'b1, 32'h2000, 4'b0100, 4'b0000, 32'h0,        1'b1, 4'b0100, 1'b1, 1'b0, 32'h12345678, ec(2)};
        vecs[12] = '{1'b1, 32'h1850, 4'b0001, 4'b0000, 32'h0,        1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        ec(2)};
        vecs[13] = '{1'b0, 32'h0,    4'b0000, 4'b0100, 32'h0BADF00D, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        ec(2)};
        vecs[14] = '{1'b1, 32'h1850, 4'b0001, 4'b0000, 32'h0,        1'b1, 4'b0001, 1'b1, 1'b0, 32'h0BADF00D, ec(2)};
        vecs[15] = '{1'b0, 32'h0,    4'b0000, 4'b0001, 32'hCAFE0000, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        ec(2)};
        vecs[16] = '{1'b1, 32'h0FFF, 4'b1111, 4'b0000, 32'h0,        1'b1, 4'b0000, 1'b1, 1'b0, 32'hCAFE0000, ec(2)};
        vecs[17] = '{1'b0, 32'h0,    4'b0000, 4'b0000, 32'h0,        1'b0, 4'b0000, 1'b1, 1'b1, 32'h0,        ec(3)};

        applyStimulus(1'b1, 1'b0, 32'h0, 4'b0, 4'b0, '0);
        applyStimulus(1'b1, 1'b0, 32'h0, 4'b0, 4'b0, '0);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b0, vecs[i].req, vecs[i].addr, vecs[i].gnt, vecs[i].rv, {NT{vecs[i].rd}});
            checkOutput($sformatf("vec%0d_gnt", i), 32'(slv_gnt_o), 32'(vecs[i].eGnt));
            checkOutput($sformatf("vec%0d_mst_req", i), 32'(mst_req_o), 32'(vecs[i].eReq));
            checkOutput($sformatf("vec%0d_rvalid", i), 32'(slv_rvalid_o), 32'(vecs[i].eRv));
            checkOutput($sformatf("vec%0d_err", i), 32'(slv_err_o), 32'(vecs[i].eErr));
            checkOutput($sformatf("vec%0d_rdata", i), slv_rdata_o, vecs[i].eRd);
            checkOutput($sformatf("vec%0d_err_cnt", i), 32'(err_cnt_o), 32'(vecs[i].eCnt));
        end

        // MaxTrans outstanding: fifth request waits until a response has been taken.
        for (int k = 0; k < MT; k++) begin
            applyStimulus(1'b0, 1'b1, 32'h1004, 4'b0010, 4'b0000, '0);
            checkOutput($sformatf("max_accept%0d", k), 32'(slv_gnt_o), 32'd1);
        end
        applyStimulus(1'b0, 1'b1, 32'h1004, 4'b0010, 4'b0000, '0);
        checkOutput("max_stall_gnt", 32'(slv_gnt_o), 32'd0);
        checkOutput("max_stall_req", 32'(mst_req_o), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h1004, 4'b0010, 4'b0010, {NT{32'h11}});
        checkOutput("max_resp_cycle_gnt", 32'(slv_gnt_o), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h1004, 4'b0010, 4'b0000, '0);
        checkOutput("max_after_resp_gnt", 32'(slv_gnt_o), 32'd1);
        checkOutput("max_after_resp_req", 32'(mst_req_o), 32'b0010);
        checkOutput("max_after_resp_rvalid", 32'(slv_rvalid_o), 32'd1);
        checkOutput("max_after_resp_rdata", slv_rdata_o, 32'h11);
        for (int k = 0; k < MT; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 4'b0000, 4'b0010, {NT{32'h22}});
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000, '0);
        checkOutput("max_drain_last_rvalid", 32'(slv_rvalid_o), 32'd1);
        checkOutput("max_drain_last_rdata", slv_rdata_o, 32'h22);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000, '0);
        checkOutput("max_drained_rvalid", 32'(slv_rvalid_o), 32'd0);

        // Reset with three outstanding requests to target 2.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 32'h2004, 4'b0100, 4'b0000, '0);
            checkOutput($sformatf("rst_pre_accept%0d", k), 32'(slv_gnt_o), 32'd1);
        end
        applyStimulus(1'b1, 1'b1, 32'h2004, 4'b0100, 4'b0000, '0);
        checkOutput("rst_during_gnt", 32'(slv_gnt_o), 32'd0);
        checkOutput("rst_during_req", 32'(mst_req_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000, '0);
        checkOutput("rst_after_rvalid", 32'(slv_rvalid_o), 32'd0);
        checkOutput("rst_after_err", 32'(slv_err_o), 32'd0);
        checkOutput("rst_after_rdata", slv_rdata_o, 32'd0);
        checkOutput("rst_after_err_cnt", 32'(err_cnt_o), 32'd0);
        checkOutput("rst_after_gnt", 32'(slv_gnt_o), 32'd0);
        checkOutput("rst_after_req", 32'(mst_req_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'b0000, 4'b0100, {NT{32'h55}});
        applyStimulus(1'b0, 1'b1, 32'h1004, 4'b0010, 4'b0000, '0);
        checkOutput("rst_late_rvalid", 32'(slv_rvalid_o), 32'd0);
        checkOutput("rst_late_err_cnt", 32'(err_cnt_o), 32'(ec(1)));
        checkOutput("rst_new_tgt_gnt", 32'(slv_gnt_o), 32'd1);
        checkOutput("rst_new_tgt_req", 32'(mst_req_o), 32'b0010);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000, '0);

        // Randomized traffic against the reference model.
        addrs = '{32'h1004, 32'h1FFC, 32'h2010, 32'h3ABC, 32'h1880, 32'h9000, 32'h0};
        for (int n = 0; n < 600; n++) begin
            rrst = ($urandom_range(99) == 0);
            rreq = ($urandom_range(3) != 0);
            for (int t = 0; t < NT; t++) rdr[t] = $urandom;
            applyStimulus(rrst, rreq, addrs[$urandom_range(6)], 4'($urandom),
                          ($urandom_range(2) == 0) ? 4'($urandom) : 4'b0000, rdr);
            checkModel();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
